mem_addr_seq: RTL and testbench

MEM_ADDR_SEQ -- requirements
Module: mem_addr_seq

---
 rtl/mem_addr_seq.sv | 116 +++++++++++
 tb/tb_mem_addr_seq.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/mem_addr_seq.sv
// Memory address sequencer: picks the memory address from PC, ALU, ALUOut or an
// exception vector, and runs a fixed-latency fetch of the vector handler address.
module mem_addr_seq #(
  parameter int ADDR_W   = 32,
  parameter int VEC_BASE = 253,
  parameter int NUM_VEC  = 3,
  parameter int MEM_LAT  = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        selector,
  input  logic [ADDR_W-1:0] PC_out,
  input  logic [ADDR_W-1:0] ALU_result,
  input  logic [ADDR_W-1:0] ALUout_out,
  input  logic              exc_req,
  input  logic [1:0]        exc_cause,
  input  logic [ADDR_W-1:0] mem_rdata,
  output logic [ADDR_W-1:0] data_out,
  output logic              addr_err,
  output logic              vec_busy,
  output logic              vec_done,
  output logic [ADDR_W-1:0] vec_target
);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_VEC_WAIT = 2'd1;
  localparam logic [1:0] S_VEC_DONE = 2'd2;

  localparam logic [ADDR_W-1:0] VB      = ADDR_W'(VEC_BASE);
  localparam logic [3:0]        SEL_LIM = 4'(3 + NUM_VEC);
  localparam logic [2:0]        CAU_LIM = 3'(NUM_VEC);
  localparam logic [2:0]        CNT_INI = 3'(MEM_LAT - 1);

  logic [1:0]        state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [1:0]        cause_q, cause_d;
  logic [ADDR_W-1:0] last_addr_q, last_addr_d;
  logic [ADDR_W-1:0] vec_target_q, vec_target_d;
  logic              addr_err_q, addr_err_d;

  logic              sel_legal;
  logic              cause_legal;
  logic [2:0]        sel_idx;
  logic [ADDR_W-1:0] sel_addr;
  logic [ADDR_W-1:0] vec_addr;

  always_comb begin
    sel_legal   = {1'b0, selector} < SEL_LIM;
    cause_legal = {1'b0, exc_cause} < CAU_LIM;
    sel_idx     = selector - 3'd3;
    vec_addr    = VB + {{(ADDR_W-2){1'b0}}, cause_q};
    case (selector)
      3'd0:    sel_addr = PC_out;
      3'd1:    sel_addr = ALU_result;
      3'd2:    sel_addr = ALUout_out;
      default: sel_addr = VB + {{(ADDR_W-3){1'b0}}, sel_idx};
    endcase

    // Once a fetch is under way the vector address owns the bus
    if (state_q == S_IDLE) data_out = sel_legal ? sel_addr : last_addr_q;
    else                   data_out = vec_addr;

    state_d      = state_q;
    cnt_d        = cnt_q;
    cause_d      = cause_q;
    last_addr_d  = last_addr_q;
    vec_target_d = vec_target_q;
    addr_err_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (sel_legal) last_addr_d = sel_addr;
        addr_err_d = !sel_legal || (exc_req && !cause_legal);
        if (exc_req && cause_legal) begin
          cause_d = exc_cause;
          cnt_d   = CNT_INI;
          state_d = S_VEC_WAIT;
        end
      end
      S_VEC_WAIT: begin
        if (cnt_q == 3'd0) begin
          vec_target_d = {{(ADDR_W-8){1'b0}}, mem_rdata[7:0]};
          state_d      = S_VEC_DONE;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      S_VEC_DONE: state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= 3'd0;
      cause_q      <= 2'd0;
      last_addr_q  <= '0;
      vec_target_q <= '0;
      addr_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      cause_q      <= cause_d;
      last_addr_q  <= last_addr_d;
      vec_target_q <= vec_target_d;
      addr_err_q   <= addr_err_d;
    end
  end

  assign addr_err   = addr_err_q;
  assign vec_busy   = (state_q != S_IDLE);
  assign vec_done   = (state_q == S_VEC_DONE);
  assign vec_target = vec_target_q;

endmodule

// File: tb/tb_mem_addr_seq.sv
// Directed bench for mem_addr_seq: one instance with default latency, one with MEM_LAT=3.
module tb_mem_addr_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  selector;
  logic [31:0] PC_out, ALU_result, ALUout_out, mem_rdata;
  logic        exc_req0, exc_req1;
  logic [1:0]  exc_cause;

  logic [31:0] data_out0, vec_target0, data_out1, vec_target1;
  logic        addr_err0, vec_busy0, vec_done0;
  logic        addr_err1, vec_busy1, vec_done1;

  int nchk = 0;
  int nerr = 0;
  int n;

  always #5 clk = ~clk;

  mem_addr_seq dut0 (
    .clk(clk), .reset(reset), .selector(selector),
    .PC_out(PC_out), .ALU_result(ALU_result), .ALUout_out(ALUout_out),
    .exc_req(exc_req0), .exc_cause(exc_cause), .mem_rdata(mem_rdata),
    .data_out(data_out0), .addr_err(addr_err0), .vec_busy(vec_busy0),
    .vec_done(vec_done0), .vec_target(vec_target0)
  );

  mem_addr_seq #(.MEM_LAT(3)) dut1 (
    .clk(clk), .reset(reset), .selector(selector),
    .PC_out(PC_out), .ALU_result(ALU_result), .ALUout_out(ALUout_out),
    .exc_req(exc_req1), .exc_cause(exc_cause), .mem_rdata(mem_rdata),
    .data_out(data_out1), .addr_err(addr_err1), .vec_busy(vec_busy1),
    .vec_done(vec_done1), .vec_target(vec_target1)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    reset = 1'b1; selector = 3'd0; exc_req0 = 1'b0; exc_req1 = 1'b0; exc_cause = 2'd0;
    PC_out = 32'h0; ALU_result = 32'h0; ALUout_out = 32'h0; mem_rdata = 32'h0;
    #2;
    check_val("rst_busy", {31'b0, vec_busy0}, 32'd0);
    check_val("rst_done", {31'b0, vec_done0}, 32'd0);
    check_val("rst_err", {31'b0, addr_err0}, 32'd0);
    check_val("rst_target", vec_target0, 32'd0);
    tick();
    reset = 1'b0;

    // Plain source selection
    PC_out = 32'h10; ALU_result = 32'h20; ALUout_out = 32'h30;
    selector = 3'd0; settle(); check_val("sel0", data_out0, 32'h10);
    selector = 3'd1; settle(); check_val("sel1", data_out0, 32'h20);
    selector = 3'd2; settle(); check_val("sel2", data_out0, 32'h30);
    check_val("sel_err", {31'b0, addr_err0}, 32'd0);
    tick();
    check_val("sel2_err", {31'b0, addr_err0}, 32'd0);

    // Vector selector then illegal selector holds last legal address
    selector = 3'd3; settle(); check_val("sel3", data_out0, 32'd253);
    selector = 3'd4; settle(); check_val("sel4", data_out0, 32'd254);
    tick();
    selector = 3'd7; settle();
    check_val("sel7_hold", data_out0, 32'd254);
    check_val("sel7_hold1", data_out1, 32'd254);
    tick();
    check_val("sel7_err", {31'b0, addr_err0}, 32'd1);
    check_val("sel7_hold2", data_out0, 32'd254);
    selector = 3'd0;
    tick();
    check_val("sel7_err_end", {31'b0, addr_err0}, 32'd0);
    check_val("sel0_back", data_out0, 32'h10);

    // Vector fetch, MEM_LAT=1
    exc_req0 = 1'b1; exc_cause = 2'd2; mem_rdata = 32'h000000A5;
    tick();
    exc_req0 = 1'b0; selector = 3'd7; settle();
    check_val("f1_busy", {31'b0, vec_busy0}, 32'd1);
    check_val("f1_wait_addr", data_out0, 32'd255);
    check_val("f1_wait_done", {31'b0, vec_done0}, 32'd0);
    tick();
    check_val("f1_done", {31'b0, vec_done0}, 32'd1);
    check_val("f1_target", vec_target0, 32'hA5);
    check_val("f1_done_addr", data_out0, 32'd255);
    check_val("f1_no_err", {31'b0, addr_err0}, 32'd0);
    selector = 3'd0;
    tick();
    check_val("f1_idle_done", {31'b0, vec_done0}, 32'd0);
    check_val("f1_idle_busy", {31'b0, vec_busy0}, 32'd0);
    check_val("f1_idle_addr", data_out0, 32'h10);

    // Illegal cause
    exc_req0 = 1'b1; exc_cause = 2'd3; mem_rdata = 32'h00000077;
    tick();
    exc_req0 = 1'b0; settle();
    check_val("bad_cause_err", {31'b0, addr_err0}, 32'd1);
    check_val("bad_cause_busy", {31'b0, vec_busy0}, 32'd0);
    tick();
    check_val("bad_cause_err_end", {31'b0, addr_err0}, 32'd0);
    check_val("bad_cause_target", vec_target0, 32'hA5);
    check_val("bad_cause_busy2", {31'b0, vec_busy0}, 32'd0);

    // MEM_LAT=3 fetch with a second request during the wait
    exc_req1 = 1'b1; exc_cause = 2'd1; mem_rdata = 32'hFFFFFF3C;
    tick();
    exc_cause = 2'd0; settle();
    check_val("l3_busy", {31'b0, vec_busy1}, 32'd1);
    check_val("l3_addr", data_out1, 32'd254);
    tick();
    exc_req1 = 1'b0; settle();
    check_val("l3_wait1_done", {31'b0, vec_done1}, 32'd0);
    check_val("l3_wait1_err", {31'b0, addr_err1}, 32'd0);
    tick();
    check_val("l3_wait2_done", {31'b0, vec_done1}, 32'd0);
    tick();
    check_val("l3_done", {31'b0, vec_done1}, 32'd1);
    check_val("l3_target", vec_target1, 32'h3C);
    check_val("l3_done_addr", data_out1, 32'd254);
    n = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (vec_done1 || vec_busy1) n++;
    end
    check_val("l3_no_requeue", n, 0);

    // Reset in the middle of a MEM_LAT=3 fetch
    exc_req1 = 1'b1; exc_cause = 2'd0; mem_rdata = 32'h000000C3;
    tick();
    exc_req1 = 1'b0;
    tick();
    selector = 3'd1; reset = 1'b1; settle();
    check_val("mid_rst_busy", {31'b0, vec_busy1}, 32'd0);
    check_val("mid_rst_target", vec_target1, 32'd0);
    check_val("mid_rst_addr", data_out1, 32'h20);
    tick();
    check_val("mid_rst_done", {31'b0, vec_done1}, 32'd0);
    reset = 1'b0;
    exc_req1 = 1'b1; exc_cause = 2'd2; mem_rdata = 32'h0000005A;
    tick();
    exc_req1 = 1'b0; settle();
    check_val("post_rst_busy", {31'b0, vec_busy1}, 32'd1);
    n = 0;
    while (!vec_done1 && n < 10) begin
      tick();
      n++;
    end
    check_val("post_rst_latency", n, 3);
    check_val("post_rst_target", vec_target1, 32'h5A);
    check_val("post_rst_addr", data_out1, 32'd255);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
